// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: loads frame_in into FFT RAM, starts FFT, unloads results to frame_out (ports: frame_ready/frame_in/frame_ack in, fft_* to FFT, frame_out/out_valid/out_ack out, busy/err status)
module fft_frame_sequencer #(
  parameter int N_POINTS    = 32,
  parameter int WORD_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_ready,
  input  logic [N_POINTS*WORD_W-1:0] frame_in,
  output logic                       frame_ack,
  output logic                       fft_load,
  output logic                       fft_start,
  output logic [ADDR_W-1:0]          fft_addr,
  output logic [WORD_W-1:0]          fft_wdata,
  input  logic                       fft_done,
  input  logic [WORD_W-1:0]          fft_rdata,
  output logic [N_POINTS*WORD_W-1:0] frame_out,
  output logic                       out_valid,
  input  logic                       out_ack,
  output logic                       busy,
  output logic                       err
);
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, UNLOAD} state_t;
  localparam logic [31:0]       TMO  = 32'(TIMEOUT_CYC);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_POINTS - 1);
  state_t                     state_q, state_d;
  logic [ADDR_W-1:0]          idx_q, idx_d, widx;
  logic [31:0]                timer_q, timer_d;
  logic                       cap_q, cap_d;
  logic [N_POINTS*WORD_W-1:0] frame_out_q, frame_out_d;
  logic                       out_valid_q, out_valid_d;
  logic                       err_q, err_d;
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    cap_d       = cap_q;
    frame_out_d = frame_out_q;
    out_valid_d = out_valid_q & ~out_ack;
    err_d       = err_q;
    widx        = (idx_q == '0) ? LAST : idx_q - 1'b1;
    case (state_q)
      IDLE: begin
        state_d = frame_ready ? LOAD : IDLE;
        idx_d   = '0;
      end
      LOAD: begin
        idx_d   = (idx_q == LAST) ? '0 : idx_q + 1'b1;
        state_d = (idx_q == LAST) ? START : LOAD;
      end
      START: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (fft_done) begin
          if (!out_valid_q) begin
            state_d = UNLOAD;
            idx_d   = '0;
            cap_d   = 1'b0;
          end
        end else if (TIMEOUT_CYC != 0 && timer_q == TMO) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = (&timer_q) ? timer_q : timer_q + 1'b1;
        end
      end
      UNLOAD: begin
        idx_d = (idx_q == LAST) ? '0 : idx_q + 1'b1;
        cap_d = 1'b1;
        if (cap_q) frame_out_d[int'(widx)*WORD_W +: WORD_W] = fft_rdata;
        // read data lags the address by one cycle, so the wrapped idx 0 marks the final capture
        if (cap_q && idx_q == '0) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          cap_d       = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      timer_q     <= '0;
      cap_q       <= 1'b0;
      frame_out_q <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      cap_q       <= cap_d;
      frame_out_q <= frame_out_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end
  always_comb begin
    fft_load  = state_q == LOAD;
    fft_start = state_q == START;
    frame_ack = state_q == START;
    busy      = state_q != IDLE;
    fft_addr  = (state_q == LOAD || state_q == UNLOAD) ? idx_q : '0;
    fft_wdata = (state_q == LOAD) ? frame_in[int'(idx_q)*WORD_W +: WORD_W] : '0;
    frame_out = frame_out_q;
    out_valid = out_valid_q;
    err       = err_q;
  end
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: directed self-checking bench for fft_frame_sequencer (default, 16-cycle and disabled watchdog instances)
module tb_fft_frame_sequencer;
  localparam int N  = 32;
  localparam int W  = 32;
  localparam int FW = N * W;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;
  logic mask_dummy;
  logic [31:0] mask;
  logic a_ready, a_fack, a_load, a_start, a_done, a_ov, a_oack, a_busy, a_err;
  logic [FW-1:0] a_in, a_fout;
  logic [4:0] a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic bc_ready, bc_done, bc_oack;
  logic [FW-1:0] bc_in;
  logic [31:0] bc_rdata;
  logic b_fack, b_load, b_start, b_ov, b_busy, b_err;
  logic c_fack, c_load, c_start, c_ov, c_busy, c_err;
  logic [4:0] b_addr, c_addr;
  logic [31:0] b_wdata, c_wdata;
  logic [FW-1:0] b_fout, c_fout;
  int checks = 0, errors = 0, a_nstart = 0, a_nack = 0, ns, nk;
  fft_frame_sequencer dut_a (
    .clk(clk), .reset(rstn), .frame_ready(a_ready), .frame_in(a_in), .frame_ack(a_fack),
    .fft_load(a_load), .fft_start(a_start), .fft_addr(a_addr), .fft_wdata(a_wdata),
    .fft_done(a_done), .fft_rdata(a_rdata), .frame_out(a_fout), .out_valid(a_ov),
    .out_ack(a_oack), .busy(a_busy), .err(a_err)
  );
  fft_frame_sequencer #(.TIMEOUT_CYC(16)) dut_b (
    .clk(clk), .reset(rstn), .frame_ready(bc_ready), .frame_in(bc_in), .frame_ack(b_fack),
    .fft_load(b_load), .fft_start(b_start), .fft_addr(b_addr), .fft_wdata(b_wdata),
    .fft_done(bc_done), .fft_rdata(bc_rdata), .frame_out(b_fout), .out_valid(b_ov),
    .out_ack(bc_oack), .busy(b_busy), .err(b_err)
  );
  fft_frame_sequencer #(.TIMEOUT_CYC(0)) dut_c (
    .clk(clk), .reset(rstn), .frame_ready(bc_ready), .frame_in(bc_in), .frame_ack(c_fack),
    .fft_load(c_load), .fft_start(c_start), .fft_addr(c_addr), .fft_wdata(c_wdata),
    .fft_done(bc_done), .fft_rdata(bc_rdata), .frame_out(c_fout), .out_valid(c_ov),
    .out_ack(bc_oack), .busy(c_busy), .err(c_err)
  );
  always @(posedge clk) begin
    a_rdata  <= {27'd0, a_addr} ^ mask;
    bc_rdata <= {27'd0, c_addr} ^ mask;
    if (a_start) a_nstart <= a_nstart + 1;
    if (a_fack) a_nack <= a_nack + 1;
  end
  function automatic logic [FW-1:0] fadd(input logic [31:0] b);
    fadd = '0;
    for (int i = 0; i < N; i++) fadd[i*W +: W] = b + 32'(i);
  endfunction
  function automatic logic [FW-1:0] fxor(input logic [31:0] m);
    fxor = '0;
    for (int i = 0; i < N; i++) fxor[i*W +: W] = 32'(i) ^ m;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic a_frame_load(input logic [31:0] base);
    a_in = fadd(base);
    a_ready = 1'b1;
    tick;
    for (int i = 0; i < N; i++) begin
      chk("load", FW'({a_load, a_start, a_addr, a_wdata}), FW'({1'b1, 1'b0, 5'(i), base + 32'(i)}));
      tick;
    end
    chk("start", FW'({a_start, a_fack, a_load, a_busy}), FW'(4'b1101));
    a_ready = 1'b0;
    a_done = 1'b0;
  endtask
  task automatic a_frame_wait(input int d);
    tick;
    repeat (d) tick;
    chk("wait", FW'({a_busy, a_load, a_start, a_addr}), FW'({3'b100, 5'd0}));
    a_done = 1'b1;
    tick;
  endtask
  task automatic a_frame_unload(input logic [31:0] m);
    for (int k = 0; k < N; k++) begin
      chk("unload", FW'({a_load, a_start, a_addr}), FW'({2'b00, 5'(k)}));
      tick;
    end
    chk("unload_last", FW'({a_addr, a_ov, a_busy}), FW'({5'd0, 2'b01}));
    tick;
    chk("out_valid", FW'({a_ov, a_busy}), FW'(2'b10));
    chk("frame_out", a_fout, fxor(m));
  endtask
  initial begin
    rstn = 1'b0; mask = '0; mask_dummy = 1'b0;
    a_ready = 1'b0; a_done = 1'b0; a_oack = 1'b0; a_in = '0;
    bc_ready = 1'b0; bc_done = 1'b0; bc_oack = 1'b0; bc_in = '0;
    repeat (2) tick;
    chk("rst_a", FW'({a_fack, a_load, a_start, a_addr, a_wdata, a_ov, a_busy, a_err}), '0);
    chk("rst_a_fout", a_fout, '0);
    chk("rst_b", FW'({b_fack, b_load, b_start, b_addr, b_wdata, b_ov, b_busy, b_err}), '0);
    chk("rst_c", FW'({c_fack, c_load, c_start, c_addr, c_wdata, c_ov, c_busy, c_err}), '0);
    rstn = 1'b1;
    tick;
    mask = 32'hFFFF_0000;
    ns = a_nstart; nk = a_nack;
    a_frame_load(32'hA500_0000);
    a_frame_wait(49);
    a_frame_unload(mask);
    chk("n_start", FW'(32'(a_nstart - ns)), FW'(32'd1));
    chk("n_ack", FW'(32'(a_nack - nk)), FW'(32'd1));
    mask = 32'h1234_0000;
    a_frame_load(32'h5A00_0000);
    tick;
    repeat (4) tick;
    a_done = 1'b1;
    repeat (10) begin
      tick;
      chk("bp_hold", FW'({a_busy, a_load, a_addr, a_ov}), FW'({2'b10, 5'd0, 1'b1}));
    end
    chk("bp_fout", a_fout, fxor(32'hFFFF_0000));
    a_oack = 1'b1;
    tick;
    a_oack = 1'b0;
    chk("bp_ack", FW'({a_ov, a_busy, a_addr}), FW'({2'b01, 5'd0}));
    tick;
    a_frame_unload(mask);
    a_oack = 1'b1;
    tick;
    chk("ack_clear", FW'(a_ov), '0);
    mask = 32'h0BAD_0000;
    a_frame_load(32'h3C00_0000);
    a_frame_wait(4);
    a_frame_unload(mask);
    tick;
    chk("sim_clear", FW'(a_ov), '0);
    a_oack = 1'b0;
    mask = 32'h00FF_0000;
    a_in = fadd(32'h7700_0000);
    a_ready = 1'b1;
    tick;
    repeat (10) tick;
    chk("rl_idx", FW'({a_load, a_addr}), FW'({1'b1, 5'd10}));
    ns = a_nstart; nk = a_nack;
    rstn = 1'b0; a_ready = 1'b0;
    tick;
    chk("rl_zero", FW'({a_fack, a_load, a_start, a_addr, a_wdata, a_ov, a_busy, a_err}), '0);
    chk("rl_fout", a_fout, '0);
    rstn = 1'b1;
    repeat (40) tick;
    chk("rl_nostart", FW'({32'(a_nstart - ns), 32'(a_nack - nk)}), '0);
    a_frame_load(32'h7700_0000);
    a_frame_wait(3);
    repeat (20) tick;
    chk("ru_idx", FW'({a_load, a_addr, a_busy}), FW'({1'b0, 5'd20, 1'b1}));
    ns = a_nstart; nk = a_nack;
    rstn = 1'b0;
    tick;
    chk("ru_zero", FW'({a_fack, a_load, a_start, a_addr, a_wdata, a_ov, a_busy, a_err}), '0);
    chk("ru_fout", a_fout, '0);
    rstn = 1'b1;
    repeat (40) tick;
    chk("ru_nostart", FW'({32'(a_nstart - ns), 32'(a_nack - nk)}), '0);
    mask = 32'h0F0F_0000;
    a_frame_load(32'h1111_0000);
    a_frame_wait(7);
    a_frame_unload(mask);
    chk("a_no_err", FW'(a_err), '0);
    mask = 32'h5555_0000;
    bc_in = fadd(32'hC000_0000);
    bc_ready = 1'b1;
    tick;
    repeat (N) tick;
    chk("bc_start", FW'({b_start, c_start, b_fack, c_fack}), FW'(4'hF));
    bc_ready = 1'b0; bc_done = 1'b0;
    tick;
    repeat (16) tick;
    chk("b_pre_to", FW'({b_err, b_busy}), FW'(2'b01));
    tick;
    chk("b_to", FW'({b_err, b_busy, b_ov, c_err, c_busy}), FW'(5'b10001));
    repeat (9980) tick;
    chk("c_wait", FW'({c_err, c_busy, c_load, c_addr, b_ov}), FW'({3'b010, 5'd0, 1'b0}));
    bc_done = 1'b1;
    tick;
    repeat (N + 1) tick;
    chk("c_done", FW'({c_ov, c_busy, c_err}), FW'(3'b100));
    chk("c_fout", c_fout, fxor(mask));
    chk("b_idle", FW'({b_ov, b_busy, b_err}), FW'(3'b001));
    chk("b_fout0", b_fout, '0);
    bc_oack = 1'b1;
    tick;
    bc_oack = 1'b0;
    chk("c_ack", FW'(c_ov), '0);
    mask = 32'hAAAA_0000;
    bc_in = fadd(32'hD000_0000);
    bc_ready = 1'b1;
    tick;
    repeat (N) tick;
    chk("bc_start2", FW'({b_start, c_start}), FW'(2'b11));
    bc_ready = 1'b0; bc_done = 1'b0;
    tick;
    repeat (5) tick;
    bc_done = 1'b1;
    tick;
    repeat (N + 1) tick;
    chk("b_good", FW'({b_ov, b_err, b_busy}), FW'(3'b110));
    chk("b_fout", b_fout, fxor(mask));
    chk("c_good", FW'({c_ov, c_err}), FW'(2'b10));
    chk("c_fout2", c_fout, fxor(mask));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
